apple_spawner: RTL

- Owns the apple position consumed by each snake's score/length tracker (apple1X/apple1Y) and by the VGA renderer.
- Places the apple at a pseudo-random legal grid cell, detects consumption by either snake head, and hides the apple immediately after it is eaten so downstream trackers count exactly one hit.
- Freezes when gameOver asserts.

---
 rtl/snake_pkg.sv | 20 ++
 rtl/lfsr16.sv | 25 ++
 rtl/apple_spawner.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/snake_pkg.sv
// Shared coordinate, apple-spawner state and LFSR tap definitions for the snake game.
// Pure declarations: no latency, no backpressure.
package snake_pkg;

    localparam int COORD_W = 7;
    localparam logic [COORD_W-1:0] OFFGRID = 7'h7F;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        SPAWN  = 2'd1,
        FROZEN = 2'd2
    } spawn_state_t;

    // Fibonacci taps for x^16 + x^14 + x^13 + x^11 + 1 (maximal length)
    localparam int LFSR_TAP_A = 15;
    localparam int LFSR_TAP_B = 13;
    localparam int LFSR_TAP_C = 12;
    localparam int LFSR_TAP_D = 10;

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, reset to SEED.
// New value every cycle, no stall input.
module lfsr16
    import snake_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] out
);

    logic fb;

    assign fb = out[LFSR_TAP_A] ^ out[LFSR_TAP_B] ^ out[LFSR_TAP_C] ^ out[LFSR_TAP_D];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out <= SEED;
        end else begin
            out <= {out[14:0], fb};
        end
    end

endmodule

// File: rtl/apple_spawner.sv
// Apple placement, consumption detection and respawn for the snake playfield.
// Outputs registered (eat pulse one cycle after the hit edge); never stalls, frozen by gameOver.
module apple_spawner
    import snake_pkg::*;
#(
    parameter int          GRID_W     = 80,
    parameter int          GRID_H     = 60,
    parameter int          INIT_X     = 40,
    parameter int          INIT_Y     = 30,
    parameter logic [15:0] SEED       = 16'hACE1,
    parameter int          MAX_TRIES  = 15,
    parameter int          FALLBACK_X = 0,
    parameter int          FALLBACK_Y = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               gameOver,
    input  logic [COORD_W-1:0] snake1X,
    input  logic [COORD_W-1:0] snake1Y,
    input  logic [COORD_W-1:0] snake2X,
    input  logic [COORD_W-1:0] snake2Y,
    output logic [COORD_W-1:0] apple1X,
    output logic [COORD_W-1:0] apple1Y,
    output logic               apple_valid,
    output logic               apple_eaten,
    output logic [1:0]         eater
);

    localparam int TRIES_W = $clog2(MAX_TRIES + 1);

    localparam logic [COORD_W:0]   GW        = GRID_W[COORD_W:0];
    localparam logic [COORD_W:0]   GH        = GRID_H[COORD_W:0];
    localparam logic [COORD_W-1:0] INIT_XC   = INIT_X[COORD_W-1:0];
    localparam logic [COORD_W-1:0] INIT_YC   = INIT_Y[COORD_W-1:0];
    localparam logic [COORD_W-1:0] FB_X      = FALLBACK_X[COORD_W-1:0];
    localparam logic [COORD_W-1:0] FB_Y      = FALLBACK_Y[COORD_W-1:0];
    localparam logic [TRIES_W-1:0] TRIES_MAX = MAX_TRIES[TRIES_W-1:0];

    spawn_state_t       state_q, state_d;
    logic [COORD_W-1:0] ax_q, ax_d, ay_q, ay_d;
    logic               valid_q, valid_d;
    logic               eaten_q, eaten_d;
    logic [1:0]         eater_q, eater_d;
    logic [TRIES_W-1:0] tries_q, tries_d;

    logic [15:0]        lfsr;
    logic [1:0]         unused_lfsr_hi;
    logic [COORD_W-1:0] cx, cy;
    logic               hit1, hit2, cand_ok, fb_ok;

    lfsr16 #(.SEED(SEED)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .out   (lfsr)
    );

    assign cx             = lfsr[6:0];
    assign cy             = lfsr[13:7];
    assign unused_lfsr_hi = lfsr[15:14];

    assign hit1 = (snake1X == ax_q) && (snake1Y == ay_q);
    assign hit2 = (snake2X == ax_q) && (snake2Y == ay_q);

    // Only heads are tested; the body may overlap a freshly spawned apple
    assign cand_ok = ({1'b0, cx} < GW) && ({1'b0, cy} < GH)
                   && !((cx == snake1X) && (cy == snake1Y))
                   && !((cx == snake2X) && (cy == snake2Y));
    assign fb_ok   = !((FB_X == snake1X) && (FB_Y == snake1Y))
                   && !((FB_X == snake2X) && (FB_Y == snake2Y));

    always_comb begin
        state_d = state_q;
        ax_d    = ax_q;
        ay_d    = ay_q;
        valid_d = valid_q;
        eaten_d = 1'b0;
        eater_d = eater_q;
        tries_d = tries_q;
        case (state_q)
            ACTIVE: begin
                if (gameOver) begin
                    state_d = FROZEN;
                end else if (hit1 || hit2) begin
                    // Hide immediately so downstream comparators match for one cycle only
                    ax_d    = OFFGRID;
                    ay_d    = OFFGRID;
                    valid_d = 1'b0;
                    eaten_d = 1'b1;
                    eater_d = {hit2, hit1};
                    tries_d = '0;
                    state_d = SPAWN;
                end
            end
            SPAWN: begin
                if (gameOver) begin
                    state_d = FROZEN;
                end else if (tries_q < TRIES_MAX) begin
                    if (cand_ok) begin
                        ax_d    = cx;
                        ay_d    = cy;
                        valid_d = 1'b1;
                        state_d = ACTIVE;
                    end else begin
                        tries_d = tries_q + TRIES_W'(1);
                    end
                end else if (fb_ok) begin
                    ax_d    = FB_X;
                    ay_d    = FB_Y;
                    valid_d = 1'b1;
                    state_d = ACTIVE;
                end else begin
                    tries_d = '0;
                end
            end
            FROZEN: begin
                state_d = FROZEN;
            end
            default: begin
                state_d = ACTIVE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ACTIVE;
            ax_q    <= INIT_XC;
            ay_q    <= INIT_YC;
            valid_q <= 1'b1;
            eaten_q <= 1'b0;
            eater_q <= 2'b00;
            tries_q <= '0;
        end else begin
            state_q <= state_d;
            ax_q    <= ax_d;
            ay_q    <= ay_d;
            valid_q <= valid_d;
            eaten_q <= eaten_d;
            eater_q <= eater_d;
            tries_q <= tries_d;
        end
    end

    assign apple1X     = ax_q;
    assign apple1Y     = ay_q;
    assign apple_valid = valid_q;
    assign apple_eaten = eaten_q;
    assign eater       = eater_q;

endmodule
